spi_reg_ctrl: RTL and testbench

Register controller for the DDS serial control port. Runs on the system clock, watches the `spi` slave's `ss`, `br` and `wordout` outputs through synchronizers, and decodes framed command/data bytes into a shadow register file. At frame end it commits that file atomically to the DDS configuration outputs: phase increment, waveform select, amplitude and run. With readback compiled in, it also drives `wordin`/`load` so the master can read registers back.

---
 rtl/spi_reg_pkg.sv | 30 +++
 rtl/sync2.sv | 24 ++
 rtl/spi_reg_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - register map, FSM states and reset values for spi_reg_ctrl
package spi_reg_pkg;

    localparam logic [6:0] REG_PH0    = 7'h00;
    localparam logic [6:0] REG_PH1    = 7'h01;
    localparam logic [6:0] REG_PH2    = 7'h02;
    localparam logic [6:0] REG_PH3    = 7'h03;
    localparam logic [6:0] REG_WAVE   = 7'h04;
    localparam logic [6:0] REG_AMP    = 7'h05;
    localparam logic [6:0] REG_RUN    = 7'h06;
    localparam logic [6:0] REG_STATUS = 7'h07;

    localparam int ST_BAD_ADDR = 0;
    localparam int ST_SHORT    = 1;

    localparam logic [31:0] PHASE_RST       = 32'h0;
    localparam logic [1:0]  WAVE_RST        = 2'b00;
    localparam logic        RUN_RST         = 1'b0;
    localparam logic [7:0]  AMP_RST_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD,
        S_DISCARD,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with parameterized reset value
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI framed register controller with atomic commit to DDS config
// Optional readback path built when SPI_READBACK_EN is defined.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         NREG    = 8,
    parameter int         B       = 8,
    parameter logic [7:0] AMP_RST = AMP_RST_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ss,
    input  logic         br,
    input  logic [B-1:0] wordout,
    output logic [B-1:0] wordin,
    output logic         load,
    output logic [31:0]  phase_inc,
    output logic [1:0]   wave_sel,
    output logic [7:0]   amplitude,
    output logic         run,
    output logic         cfg_update
);

    localparam int AW = $clog2(NREG);

    logic          ss_s, br_s, ss_d, br_prev;
    logic          ss_fall, ss_rise, byte_det;
    logic [7:0]    rx;
    logic [6:0]    cmd_addr;
    logic          cmd_bad;
    logic [AW-1:0] addr;
    logic [6:0]    addr7;
    logic          got_data;
    logic [31:0]   sh_phase;
    logic [1:0]    sh_wave;
    logic [7:0]    sh_amp;
    logic          sh_run;
    logic [1:0]    status;
    state_t        state, state_n;

    sync2 #(.RST_VAL(1'b1)) u_sync_ss (.clk(clk), .rst_n(rst_n), .d(ss), .q(ss_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_br (.clk(clk), .rst_n(rst_n), .d(br), .q(br_s));

    // Edge history; br history is held high outside a frame so the counter-0 level at frame start makes no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_d    <= 1'b1;
            br_prev <= 1'b1;
        end else begin
            ss_d    <= ss_s;
            br_prev <= ss_s ? 1'b1 : br_s;
        end
    end

    assign ss_fall  = ss_d & ~ss_s;
    assign ss_rise  = ~ss_d & ss_s;
    assign byte_det = ~ss_s & br_s & ~br_prev;
    assign rx       = wordout[7:0];
    assign cmd_addr = rx[6:0];
    assign cmd_bad  = (cmd_addr >= 7'(NREG));
    assign addr7    = 7'(addr);
    assign cfg_update = (state == S_COMMIT);

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Frame sequencing: command byte picks the path, ss rise ends the frame.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (ss_fall) state_n = S_CMD;
            S_CMD: begin
                if (ss_rise) state_n = S_IDLE;
                else if (byte_det) begin
                    if (cmd_bad)    state_n = S_DISCARD;
                    else if (rx[7]) state_n = S_WR;
`ifdef SPI_READBACK_EN
                    else            state_n = S_RD;
`else
                    else            state_n = S_DISCARD;
`endif
                end
            end
            S_WR:      if (ss_rise) state_n = got_data ? S_COMMIT : S_IDLE;
            S_RD:      if (ss_rise) state_n = S_IDLE;
            S_DISCARD: if (ss_rise) state_n = S_IDLE;
            S_COMMIT:  state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Shadow file writes, status flags, address tracking and the atomic commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            got_data  <= 1'b0;
            sh_phase  <= PHASE_RST;
            sh_wave   <= WAVE_RST;
            sh_amp    <= AMP_RST;
            sh_run    <= RUN_RST;
            status    <= 2'b00;
            phase_inc <= PHASE_RST;
            wave_sel  <= WAVE_RST;
            amplitude <= AMP_RST;
            run       <= RUN_RST;
        end else begin
            case (state)
                S_CMD: begin
                    if (byte_det) begin
                        addr     <= cmd_addr[AW-1:0];
                        got_data <= 1'b0;
                        if (cmd_bad) status[ST_BAD_ADDR] <= 1'b1;
`ifdef SPI_READBACK_EN
                        else if (!rx[7]) addr <= cmd_addr[AW-1:0] + AW'(1);
`endif
                    end
                end
                S_WR: begin
                    if (byte_det) begin
                        case (addr7)
                            REG_PH0:    sh_phase[7:0]   <= rx;
                            REG_PH1:    sh_phase[15:8]  <= rx;
                            REG_PH2:    sh_phase[23:16] <= rx;
                            REG_PH3:    sh_phase[31:24] <= rx;
                            REG_WAVE:   sh_wave         <= rx[1:0];
                            REG_AMP:    sh_amp          <= rx;
                            REG_RUN:    sh_run          <= rx[0];
                            REG_STATUS: status          <= status & ~rx[1:0];
                            default: ;
                        endcase
                        addr     <= addr + AW'(1);
                        got_data <= 1'b1;
                    end
                    if (ss_rise) begin
                        if (got_data) begin
                            phase_inc <= sh_phase;
                            wave_sel  <= sh_wave;
                            amplitude <= sh_amp;
                            run       <= sh_run;
                        end else begin
                            status[ST_SHORT] <= 1'b1;
                        end
                    end
                end
`ifdef SPI_READBACK_EN
                S_RD: begin
                    if (byte_det) begin
                        addr     <= addr + AW'(1);
                        got_data <= 1'b1;
                    end
                    if (ss_rise && !got_data) status[ST_SHORT] <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [6:0] rd_addr;
    logic [7:0] rd_byte;
    logic [7:0] wordin_r;

    // Readback mux over the shadow file; in the command cycle the address comes from the byte itself.
    always_comb begin
        rd_addr = (state == S_CMD) ? cmd_addr : addr7;
        rd_byte = 8'h00;
        case (rd_addr)
            REG_PH0:    rd_byte = sh_phase[7:0];
            REG_PH1:    rd_byte = sh_phase[15:8];
            REG_PH2:    rd_byte = sh_phase[23:16];
            REG_PH3:    rd_byte = sh_phase[31:24];
            REG_WAVE:   rd_byte = {6'b0, sh_wave};
            REG_AMP:    rd_byte = sh_amp;
            REG_RUN:    rd_byte = {7'b0, sh_run};
            REG_STATUS: rd_byte = {6'b0, status};
            default:    rd_byte = 8'h00;
        endcase
    end

    // Readback byte latched at each detected byte of a read frame and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wordin_r <= 8'h00;
        end else if (byte_det) begin
            if ((state == S_CMD && !cmd_bad && !rx[7]) || state == S_RD) wordin_r <= rd_byte;
        end
    end

    assign wordin = B'(wordin_r);
    assign load   = (state == S_RD);
`else
    // Status is only visible through readback; keep it as part of the register map.
    logic unused_status;
    assign unused_status = ^status;
    assign wordin = '0;
    assign load   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - self-checking bench for spi_reg_ctrl with a register-map reference model
module tb_spi_reg_ctrl;

    localparam int SCLK = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss = 1'b1;
    logic        br = 1'b1;
    logic [7:0]  wordout = 8'h00;
    logic [7:0]  wordin;
    logic        load;
    logic [31:0] phase_inc;
    logic [1:0]  wave_sel;
    logic [7:0]  amplitude;
    logic        run;
    logic        cfg_update;

    spi_reg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ss(ss), .br(br), .wordout(wordout),
        .wordin(wordin), .load(load), .phase_inc(phase_inc), .wave_sel(wave_sel),
        .amplitude(amplitude), .run(run), .cfg_update(cfg_update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int hi_cycles = 0;

    always @(negedge clk) if (cfg_update === 1'b1) hi_cycles++;

    logic [7:0] m_sh[8];
    logic [7:0] m_act[7];
    logic [7:0] fq[$];
    logic [7:0] rbq[$];

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_sh[i] = 8'h00;
        m_sh[5] = 8'hFF;
        for (int i = 0; i < 7; i++) m_act[i] = m_sh[i];
    endfunction

    function automatic logic [42:0] exp_out();
        return {m_act[3], m_act[2], m_act[1], m_act[0], m_act[4][1:0], m_act[5], m_act[6][0]};
    endfunction

    // Applies the frame in fq to the model; returns number of commits, fills rbq with expected readback.
    function automatic int model_frame();
        logic [7:0] c, d;
        int a, nd;
        c = fq[0];
        nd = fq.size() - 1;
        rbq.delete();
        if (c[6:0] >= 7'd8) begin
            m_sh[7] = m_sh[7] | 8'h01;
            return 0;
        end
        a = int'(c[6:0]);
        if (c[7]) begin
            for (int i = 1; i <= nd; i++) begin
                d = fq[i];
                if (a == 7)      m_sh[7] = m_sh[7] & ~d & 8'h03;
                else if (a == 4) m_sh[4] = d & 8'h03;
                else if (a == 6) m_sh[6] = d & 8'h01;
                else             m_sh[a] = d;
                a = (a + 1) % 8;
            end
            if (nd == 0) begin
                m_sh[7] = m_sh[7] | 8'h02;
                return 0;
            end
            for (int k = 0; k < 7; k++) m_act[k] = m_sh[k];
            return 1;
        end
`ifdef SPI_READBACK_EN
        for (int i = 0; i <= nd; i++) rbq.push_back(m_sh[(a + i) % 8]);
        if (nd == 0) m_sh[7] = m_sh[7] | 8'h02;
`endif
        return 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        ss = 1'b0;
        br = 1'b1;
        tick(SCLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        br = 1'b0;
        wordout = 8'($urandom);
        tick(7 * SCLK);
        wordout = b;
        br = 1'b1;
        tick(SCLK);
    endtask

    task automatic frame_end(output int lat, output int pulses);
        int h0;
        h0 = hi_cycles;
        ss = 1'b1;
        wordout = 8'($urandom);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k == 1) br = 1'b1;
            if (cfg_update === 1'b1 && lat < 0) lat = k;
        end
        pulses = hi_cycles - h0;
        tick(SCLK);
    endtask

    task automatic do_frame(output int lat, output int pulses);
        frame_start();
        foreach (fq[i]) send_byte(fq[i]);
        frame_end(lat, pulses);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ss = 1'b1;
        br = 1'b1;
        model_reset();
        tick(3);
        n_checks++;
        if ({phase_inc, wave_sel, amplitude, run} !== exp_out())
            $display("FAIL reset_outputs got %h want %h", {phase_inc, wave_sel, amplitude, run}, exp_out());
        else n_pass++;
        n_checks++;
        if ({cfg_update, load, wordin} !== 10'h0)
            $display("FAIL reset_ctrl got cfg=%b load=%b wordin=%h want 0", cfg_update, load, wordin);
        else n_pass++;
        n_checks++;
        if (dut.status !== 2'b00) $display("FAIL reset_status got %b want 00", dut.status);
        else n_pass++;
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_phase_write();
        int lat, pulses, commits;
        logic [42:0] pre;
        fq = '{8'h80, 8'h78, 8'h56, 8'h34, 8'h12};
        pre = exp_out();
        commits = model_frame();
        frame_start();
        foreach (fq[i]) send_byte(fq[i]);
        n_checks++;
        if ({phase_inc, wave_sel, amplitude, run} !== pre)
            $display("FAIL phase_before_commit got %h want %h", {phase_inc, wave_sel, amplitude, run}, pre);
        else n_pass++;
        frame_end(lat, pulses);
        n_checks++;
        if (lat !== 3) $display("FAIL commit_latency got %0d want 3", lat);
        else n_pass++;
        n_checks++;
        if (pulses !== commits) $display("FAIL phase_pulses got %0d want %0d", pulses, commits);
        else n_pass++;
        n_checks++;
        if (phase_inc !== 32'h12345678) $display("FAIL phase_value got %h want 12345678", phase_inc);
        else n_pass++;
        n_checks++;
        if ({phase_inc, wave_sel, amplitude, run} !== exp_out())
            $display("FAIL phase_outputs got %h want %h", {phase_inc, wave_sel, amplitude, run}, exp_out());
        else n_pass++;
    endtask

    task automatic test_partial_byte();
        int lat, pulses, commits;
        fq = '{8'h85, 8'h40};
        commits = model_frame();
        frame_start();
        foreach (fq[i]) send_byte(fq[i]);
        br = 1'b0;
        wordout = 8'h99;
        tick(3 * SCLK);
        frame_end(lat, pulses);
        n_checks++;
        if (pulses !== commits) $display("FAIL partial_pulses got %0d want %0d", pulses, commits);
        else n_pass++;
        n_checks++;
        if (amplitude !== 8'h40) $display("FAIL partial_amplitude got %h want 40", amplitude);
        else n_pass++;
        n_checks++;
        if ({phase_inc, wave_sel, amplitude, run} !== exp_out())
            $display("FAIL partial_outputs got %h want %h", {phase_inc, wave_sel, amplitude, run}, exp_out());
        else n_pass++;
    endtask

    task automatic test_bad_address();
        int lat, pulses, commits;
        logic [42:0] pre;
        fq = '{8'h90, 8'h11, 8'h22};
        pre = exp_out();
        commits = model_frame();
        do_frame(lat, pulses);
        n_checks++;
        if (pulses !== 0) $display("FAIL badaddr_pulses got %0d want 0", pulses);
        else n_pass++;
        n_checks++;
        if ({phase_inc, wave_sel, amplitude, run} !== pre)
            $display("FAIL badaddr_outputs got %h want %h", {phase_inc, wave_sel, amplitude, run}, pre);
        else n_pass++;
        n_checks++;
        if (dut.status !== 2'b01) $display("FAIL badaddr_status got %b want 01", dut.status);
        else n_pass++;
        fq = '{8'h87, 8'h01};
        commits = model_frame();
        do_frame(lat, pulses);
        n_checks++;
        if (pulses !== commits) $display("FAIL w1c_pulses got %0d want %0d", pulses, commits);
        else n_pass++;
        n_checks++;
        if (dut.status !== 2'b00) $display("FAIL w1c_status got %b want 00", dut.status);
        else n_pass++;
    endtask

    task automatic test_short_frame();
        int lat, pulses, commits;
        logic [42:0] pre;
        fq = '{8'h86};
        pre = exp_out();
        commits = model_frame();
        do_frame(lat, pulses);
        n_checks++;
        if (pulses !== 0) $display("FAIL short_pulses got %0d want 0", pulses);
        else n_pass++;
        n_checks++;
        if (dut.status !== 2'b10) $display("FAIL short_status got %b want 10", dut.status);
        else n_pass++;
        n_checks++;
        if ({phase_inc, wave_sel, amplitude, run} !== pre)
            $display("FAIL short_outputs got %h want %h", {phase_inc, wave_sel, amplitude, run}, pre);
        else n_pass++;
        fq = '{8'h87, 8'h02};
        commits = model_frame();
        do_frame(lat, pulses);
        n_checks++;
        if (dut.status !== m_sh[7][1:0]) $display("FAIL short_clear got %b want %b", dut.status, m_sh[7][1:0]);
        else n_pass++;
    endtask

    task automatic test_readback();
        int lat, pulses, commits;
        fq = '{8'h85, 8'hA5};
        commits = model_frame();
        do_frame(lat, pulses);
        fq = '{8'h05, 8'h3C};
        commits = model_frame();
        frame_start();
        send_byte(fq[0]);
`ifdef SPI_READBACK_EN
        n_checks++;
        if (load !== 1'b1 || wordin !== 8'hA5)
            $display("FAIL readback_cmd got load=%b wordin=%h want load=1 wordin=a5", load, wordin);
        else n_pass++;
        send_byte(fq[1]);
        n_checks++;
        if (load !== 1'b1 || wordin !== rbq[1])
            $display("FAIL readback_next got load=%b wordin=%h want load=1 wordin=%h", load, wordin, rbq[1]);
        else n_pass++;
`else
        n_checks++;
        if (load !== 1'b0 || wordin !== 8'h00)
            $display("FAIL readback_off got load=%b wordin=%h want 0/00", load, wordin);
        else n_pass++;
        send_byte(fq[1]);
`endif
        frame_end(lat, pulses);
        n_checks++;
        if (load !== 1'b0 || pulses !== 0)
            $display("FAIL readback_end got load=%b pulses=%0d want 0/0", load, pulses);
        else n_pass++;
        n_checks++;
        if (dut.status !== m_sh[7][1:0]) $display("FAIL readback_status got %b want %b", dut.status, m_sh[7][1:0]);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        int lat, pulses, commits, kind, n;
        bit is_rd;
        for (int it = 0; it < 12; it++) begin
            fq.delete();
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                fq.push_back(8'h80 | 8'($urandom_range(0, 7)));
                n = int'($urandom_range(0, 5));
            end else if (kind < 9) begin
                fq.push_back(8'($urandom_range(0, 7)));
                n = int'($urandom_range(0, 3));
            end else begin
                fq.push_back(8'(($urandom_range(0, 1) << 7) | $urandom_range(8, 127)));
                n = int'($urandom_range(0, 2));
            end
            for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
            is_rd = !fq[0][7] && (fq[0][6:0] < 7'd8);
            commits = model_frame();
            frame_start();
            for (int i = 0; i < fq.size(); i++) begin
                send_byte(fq[i]);
`ifdef SPI_READBACK_EN
                if (is_rd) begin
                    n_checks++;
                    if (load !== 1'b1 || wordin !== rbq[i])
                        $display("FAIL rand_readback it=%0d byte=%0d got load=%b wordin=%h want 1/%h",
                                 it, i, load, wordin, rbq[i]);
                    else n_pass++;
                end
`else
                if (is_rd) begin
                    n_checks++;
                    if (load !== 1'b0) $display("FAIL rand_load_off it=%0d got %b want 0", it, load);
                    else n_pass++;
                end
`endif
            end
            frame_end(lat, pulses);
            n_checks++;
            if (pulses !== commits) $display("FAIL rand_pulses it=%0d got %0d want %0d", it, pulses, commits);
            else n_pass++;
            n_checks++;
            if ({phase_inc, wave_sel, amplitude, run} !== exp_out())
                $display("FAIL rand_outputs it=%0d got %h want %h", it, {phase_inc, wave_sel, amplitude, run}, exp_out());
            else n_pass++;
            n_checks++;
            if (dut.status !== m_sh[7][1:0] || load !== 1'b0)
                $display("FAIL rand_status it=%0d got %b load=%b want %b load=0", it, dut.status, load, m_sh[7][1:0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat, pulses, commits;
        frame_start();
        send_byte(8'h80);
        send_byte(8'hAA);
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({phase_inc, wave_sel, amplitude, run} !== exp_out())
            $display("FAIL midreset_outputs got %h want %h", {phase_inc, wave_sel, amplitude, run}, exp_out());
        else n_pass++;
        n_checks++;
        if ({cfg_update, load, wordin} !== 10'h0 || dut.status !== 2'b00)
            $display("FAIL midreset_ctrl got cfg=%b load=%b wordin=%h status=%b want 0", cfg_update, load, wordin, dut.status);
        else n_pass++;
        ss = 1'b1;
        br = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        fq = '{8'h84, 8'h03, 8'h77, 8'h01};
        commits = model_frame();
        do_frame(lat, pulses);
        n_checks++;
        if (pulses !== commits || lat !== 3)
            $display("FAIL postreset_commit got pulses=%0d lat=%0d want %0d/3", pulses, lat, commits);
        else n_pass++;
        n_checks++;
        if ({wave_sel, amplitude, run} !== {2'd3, 8'h77, 1'b1})
            $display("FAIL postreset_values got %h want %h", {wave_sel, amplitude, run}, {2'd3, 8'h77, 1'b1});
        else n_pass++;
        n_checks++;
        if ({phase_inc, wave_sel, amplitude, run} !== exp_out())
            $display("FAIL postreset_outputs got %h want %h", {phase_inc, wave_sel, amplitude, run}, exp_out());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_phase_write();
        test_partial_byte();
        test_bad_address();
        test_short_frame();
        test_readback();
        test_random_frames();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
